// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, optional two-entry skid and stall counter
// Ports: clk, rst (async, active-high), flush (sync squash), in_valid/in_ready/in_data (upstream),
//        out_valid/out_ready/out_data (downstream, oldest entry), occupancy (0..2), stall_cnt (saturating).
module pipe_stage_reg #(
  parameter int WIDTH = 128,
  parameter bit SKID = 1,
  parameter bit CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [15:0]      stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  logic [WIDTH-1:0] main_q;
  logic in_fire, out_fire;
  assign out_data = main_q;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
  if (SKID) begin : g_skid
    state_t state, state_nx;
    logic [WIDTH-1:0] skid_q, main_nx, skid_nx;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        state <= EMPTY;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        state <= state_nx;
        main_q <= main_nx;
        skid_q <= skid_nx;
      end
    always_comb begin
      state_nx = state;
      main_nx = main_q;
      skid_nx = skid_q;
      if (flush) begin
        state_nx = EMPTY;
        main_nx = CLEAR_ON_FLUSH ? '0 : main_q;
        skid_nx = CLEAR_ON_FLUSH ? '0 : skid_q;
      end else
        case (state)
          EMPTY: if (in_fire) begin
            state_nx = ONE;
            main_nx = in_data;
          end
          ONE: if (in_fire & out_fire) main_nx = in_data;
          else if (in_fire) begin
            state_nx = FULL;
            skid_nx = in_data;
          end else if (out_fire) state_nx = EMPTY;
          FULL: if (out_fire) begin
            state_nx = ONE;
            main_nx = skid_q;
          end
          default: state_nx = EMPTY;
        endcase
    end
    // in_ready depends on state only, so no combinational path from out_ready
    assign in_ready = ~rst & (state != FULL);
    assign out_valid = state != EMPTY;
    assign occupancy = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  end else begin : g_single
    logic valid_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        valid_q <= 1'b0;
        main_q <= '0;
      end else if (flush) begin
        valid_q <= 1'b0;
        main_q <= CLEAR_ON_FLUSH ? '0 : main_q;
      end else if (in_fire) begin
        valid_q <= 1'b1;
        main_q <= in_data;
      end else if (out_fire) valid_q <= 1'b0;
    // accepting while the held beat leaves this cycle replaces it without a bubble
    assign in_ready = ~rst & (out_ready | ~valid_q);
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: random plus directed checks of both pipe_stage_reg variants against a FIFO model
module tb_pipe_stage_reg;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [1:0] ir, ov;
  logic [1:0][31:0] od;
  logic [1:0][1:0] occ;
  logic [1:0][15:0] sc;
  int checks = 0, errors = 0;
  int cnt[2], msc[2];
  logic [31:0] m[2][2];
  logic [31:0] dlv[$];
  always #5 clk = ~clk;
  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CLEAR_ON_FLUSH(0)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(occ[0]), .stall_cnt(sc[0]));
  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CLEAR_ON_FLUSH(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(occ[1]), .stall_cnt(sc[1]));
  task automatic cmp(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, a, e, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // model: a FIFO of capacity 2 (skid) or 1 (single), updated once per cycle from the stable inputs
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit eir, of, inf;
      if (rst) begin
        cmp("rst_in_ready", k, 32'(ir[k]), 32'd0);
        cmp("rst_out_valid", k, 32'(ov[k]), 32'd0);
        cmp("rst_occupancy", k, 32'(occ[k]), 32'd0);
        cmp("rst_stall_cnt", k, 32'(sc[k]), 32'd0);
        cnt[k] = 0;
        msc[k] = 0;
      end else begin
        eir = k == 1 ? cnt[k] < 2 : (cnt[k] == 0 || out_ready);
        cmp("in_ready", k, 32'(ir[k]), 32'(eir));
        cmp("out_valid", k, 32'(ov[k]), 32'(cnt[k] > 0));
        cmp("occupancy", k, 32'(occ[k]), cnt[k]);
        cmp("stall_cnt", k, 32'(sc[k]), msc[k]);
        if (cnt[k] > 0) cmp("out_data", k, od[k], m[k][0]);
        of = cnt[k] > 0 && out_ready;
        inf = in_valid && eir;
        if (k == 1 && of) dlv.push_back(m[1][0]);
        if (cnt[k] > 0 && !out_ready && msc[k] < 65535) msc[k]++;
        if (flush) cnt[k] = 0;
        else begin
          if (of) begin
            m[k][0] = m[k][1];
            cnt[k]--;
          end
          if (inf) begin
            m[k][cnt[k]] = in_data;
            cnt[k]++;
          end
        end
      end
    end
  end
  task automatic pulse_rst();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  initial begin
    step();
    step();
    rst = 0;
    step();
    cmp("post_rst_in_ready", 1, 32'(ir[1]), 32'd1);
    cmp("post_rst_out_data", 1, od[1], 32'd0);
    // back-to-back streaming, no bubbles
    out_ready = 1;
    in_valid = 1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      step();
      cmp("stream_data", 1, od[1], i);
      cmp("stream_valid", 1, 32'(ov[1]), 32'd1);
    end
    in_valid = 0;
    step();
    cmp("stream_stall", 1, 32'(sc[1]), 32'd0);
    // fill the skid while stalled, then drain in order
    dlv.delete();
    out_ready = 0;
    in_valid = 1;
    in_data = 32'h11;
    step();
    in_data = 32'h22;
    step();
    cmp("full_occupancy", 1, 32'(occ[1]), 32'd2);
    cmp("full_in_ready", 1, 32'(ir[1]), 32'd0);
    in_data = 32'h33;
    step();
    step();
    cmp("stall_count", 1, 32'(sc[1]), 32'd3);
    out_ready = 1;
    step();
    step();
    in_valid = 0;
    step();
    cmp("drain_count", 1, dlv.size(), 3);
    if (dlv.size() == 3) begin
      cmp("drain0", 1, dlv[0], 32'h11);
      cmp("drain1", 1, dlv[1], 32'h22);
      cmp("drain2", 1, dlv[2], 32'h33);
    end
    // flush while full with a beat offered
    out_ready = 0;
    in_valid = 1;
    in_data = 32'h55;
    step();
    in_data = 32'h66;
    step();
    dlv.delete();
    in_data = 32'h44;
    flush = 1;
    step();
    flush = 0;
    in_valid = 0;
    cmp("flush_valid", 1, 32'(ov[1]), 32'd0);
    cmp("flush_occupancy", 1, 32'(occ[1]), 32'd0);
    cmp("flush_data", 1, od[1], 32'd0);
    out_ready = 1;
    repeat (3) step();
    cmp("flush_dropped", 1, dlv.size(), 0);
    // async reset between edges
    out_ready = 0;
    in_valid = 1;
    in_data = 32'hA5A5A5A5;
    step();
    in_valid = 0;
    cmp("held_data", 1, od[1], 32'hA5A5A5A5);
    #2 rst = 1;
    #1;
    cmp("async_valid", 1, 32'(ov[1]), 32'd0);
    cmp("async_data", 1, od[1], 32'd0);
    cmp("async_occupancy", 1, 32'(occ[1]), 32'd0);
    cmp("async_in_ready", 1, 32'(ir[1]), 32'd0);
    cmp("async_in_ready", 0, 32'(ir[0]), 32'd0);
    step();
    step();
    rst = 0;
    // long stall saturates the counter
    in_valid = 1;
    in_data = 32'h7;
    step();
    in_valid = 0;
    repeat (70000) @(posedge clk);
    #1;
    cmp("stall_sat", 1, 32'(sc[1]), 32'hFFFF);
    repeat (10) step();
    cmp("stall_sat_hold", 1, 32'(sc[1]), 32'hFFFF);
    cmp("stall_sat_hold", 0, 32'(sc[0]), 32'hFFFF);
    pulse_rst();
    // single-entry variant: in_ready follows out_ready within the cycle
    in_valid = 1;
    in_data = 32'h10;
    step();
    in_data = 32'h20;
    cmp("comb_ready_low", 0, 32'(ir[0]), 32'd0);
    #1 out_ready = 1;
    #1;
    cmp("comb_ready_high", 0, 32'(ir[0]), 32'd1);
    step();
    cmp("replace_data", 0, od[0], 32'h20);
    cmp("replace_valid", 0, 32'(ov[0]), 32'd1);
    in_valid = 0;
    step();
    // randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 32) == 0;
      in_data = $urandom;
      step();
    end
    flush = 0;
    in_valid = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
